// File: rtl/chroma_upsampler.sv
// Horizontal 2:1 chroma upsampler: streams U then V rows from SRAM, writes full-width U'/V' planes.
// Optional CHROMA_UPSAMPLE_ROUND_EN selects round-half-up averaging instead of truncation.
module chroma_upsampler #(
  parameter int AW              = 18,
  parameter int DW              = 16,
  parameter int W               = 320,
  parameter int H               = 240,
  parameter int READ_ADDR_BASE  = 76800,
  parameter int WRITE_ADDR_BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int SW = DW / 2;
  localparam int NW = W / 4;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [AW-1:0] U_RD_BASE = AW'(READ_ADDR_BASE);
  localparam logic [AW-1:0] V_RD_BASE = AW'(READ_ADDR_BASE + (W * H) / 4);
  localparam logic [AW-1:0] U_WR_BASE = AW'(WRITE_ADDR_BASE);
  localparam logic [AW-1:0] V_WR_BASE = AW'(WRITE_ADDR_BASE + (W * H) / 2);
  localparam logic [AW-1:0] ROW_STEP  = AW'(NW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_LOAD,
    S_RUN,
    S_PLANE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_plane_v;
  logic [RW-1:0] r_row;
  logic [KW-1:0] r_k;
  logic          r_ph;
  logic [AW-1:0] r_rrow;
  logic [AW-1:0] r_wptr;
  logic [DW-1:0] r_cur;
  logic [DW-1:0] r_nxt;

  logic [AW-1:0] r_raddr;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_wr_enable;
  logic          r_done;

  function automatic logic [SW-1:0] avg(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW:0] s;
`ifdef CHROMA_UPSAMPLE_ROUND_EN
    s = {1'b0, a} + {1'b0, b} + (SW+1)'(1);
`else
    s = {1'b0, a} + {1'b0, b};
`endif
    return s[SW:1];
  endfunction

  logic [SW-1:0] w_cur_hi;
  logic [SW-1:0] w_cur_lo;
  logic [SW-1:0] w_next_hi;
  logic          w_last_word;
  logic          w_has_k2;
  logic          w_last_row;

  assign w_cur_hi    = r_cur[DW-1:SW];
  assign w_cur_lo    = r_cur[SW-1:0];
  assign w_last_word = (r_k == KW'(NW - 1));
  assign w_has_k2    = ((int'(r_k) + 2) < NW);
  assign w_last_row  = (r_row == RW'(H - 1));
  // The row's final odd output replicates its own sample instead of peeking at the next row.
  assign w_next_hi   = w_last_word ? w_cur_lo : r_nxt[DW-1:SW];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_plane_v   <= 1'b0;
      r_row       <= '0;
      r_k         <= '0;
      r_ph        <= 1'b0;
      r_rrow      <= '0;
      r_wptr      <= '0;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_wr_enable <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_enable <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_plane_v <= 1'b0;
            r_row     <= '0;
            r_rrow    <= U_RD_BASE;
            r_raddr   <= U_RD_BASE;
            r_wptr    <= U_WR_BASE;
            r_state   <= S_PRIME;
          end
        end
        S_PRIME: begin
          r_k  <= '0;
          r_ph <= 1'b0;
          if (NW > 1) r_raddr <= r_rrow + AW'(1);
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_cur   <= rdata;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_wr_enable <= 1'b1;
          r_waddr     <= r_wptr;
          r_wptr      <= r_wptr + AW'(1);
          if (!r_ph) begin
            // rdata carries word k+1 here; the next read is only issued if it stays inside the row.
            if (!w_last_word) r_nxt <= rdata;
            if (w_has_k2) r_raddr <= r_rrow + AW'(r_k) + AW'(2);
            r_wdata <= {w_cur_hi, avg(w_cur_hi, w_cur_lo)};
            r_ph    <= 1'b1;
          end else begin
            r_wdata <= {w_cur_lo, avg(w_cur_lo, w_next_hi)};
            r_ph    <= 1'b0;
            r_cur   <= r_nxt;
            r_k     <= r_k + KW'(1);
            if (w_last_word) begin
              if (w_last_row) begin
                r_state <= S_PLANE;
              end else begin
                r_row   <= r_row + RW'(1);
                r_rrow  <= r_rrow + ROW_STEP;
                r_raddr <= r_rrow + ROW_STEP;
                r_state <= S_PRIME;
              end
            end
          end
        end
        S_PLANE: begin
          if (!r_plane_v) begin
            r_plane_v <= 1'b1;
            r_row     <= '0;
            r_rrow    <= V_RD_BASE;
            r_raddr   <= V_RD_BASE;
            r_wptr    <= V_WR_BASE;
            r_state   <= S_PRIME;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign raddr     = r_raddr;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign wr_enable = r_wr_enable;

endmodule

// File: tb/tb_chroma_upsampler.sv
// Bench for chroma_upsampler on an 8x2 image with a behavioural SRAM and sample-level reference model.
module tb_chroma_upsampler;
  localparam int AW     = 18;
  localparam int DW     = 16;
  localparam int W      = 8;
  localparam int H      = 2;
  localparam int RB     = 100;
  localparam int WB     = 200;
  localparam int NWR    = W * H;
  localparam int MAXCYC = W * H + 8 * H + 4;
`ifdef CHROMA_UPSAMPLE_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wr_enable;

  logic [15:0] mem  [0:255];
  logic [15:0] wmem [0:NWR-1];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int bad_waddr = 0;

  always #5 clk = ~clk;

  chroma_upsampler #(
    .AW(AW), .DW(DW), .W(W), .H(H), .READ_ADDR_BASE(RB), .WRITE_ADDR_BASE(WB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata), .wr_enable(wr_enable)
  );

  always @(posedge clk) rdata <= mem[raddr[7:0]];

  always @(negedge clk) begin
    if (wr_enable) begin
      wr_cnt++;
      if (int'(waddr) >= WB && int'(waddr) < WB + NWR) wmem[int'(waddr) - WB] = wdata;
      else bad_waddr++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] samp(input int p, input int r, input int i);
    logic [15:0] w;
    w = mem[8'(RB + p * (W * H / 4) + r * (W / 4) + i / 2)];
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] model(input int p, input int r, input int j);
    int a;
    int b;
    int s;
    a = int'(samp(p, r, j));
    b = (j + 1 < W / 2) ? int'(samp(p, r, j + 1)) : a;
    s = (a + b + RND) / 2;
    return {8'(a), 8'(s)};
  endfunction

  task automatic check_image(input string tag);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < H; r++)
        for (int j = 0; j < W / 2; j++)
          check($sformatf("%s_p%0d_r%0d_j%0d", tag, p, r, j),
                32'(wmem[p * (W * H / 2) + r * (W / 2) + j]), 32'(model(p, r, j)));
  endtask

  task automatic clear_results();
    for (int i = 0; i < NWR; i++) wmem[i] = 'x;
    wr_cnt = 0;
    done_cnt = 0;
    bad_waddr = 0;
  endtask

  task automatic fill_random();
    for (int i = RB; i < RB + 8; i++) mem[i] = 16'($urandom);
  endtask

  task automatic run(input bit start_on_done, output int cyc, output int bad_rd);
    cyc = 0;
    bad_rd = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!done && cyc < 200) begin
      if (int'(raddr) < RB || int'(raddr) > RB + 7) bad_rd++;
      @(negedge clk);
      cyc++;
    end
    if (start_on_done && done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_run(input string tag, input int cyc, input int bad_rd);
    repeat (3) @(negedge clk);
    check({tag, "_within_budget"}, 32'(cyc <= MAXCYC), 32'd1);
    check({tag, "_write_count"}, 32'(wr_cnt), 32'(NWR));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_bad_raddr"}, 32'(bad_rd), 32'd0);
    check({tag, "_bad_waddr"}, 32'(bad_waddr), 32'd0);
    check_image(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_wr_enable"}, 32'(wr_enable), 32'd0);
    check({tag, "_raddr"}, 32'(raddr), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
  endtask

  initial begin
    int cyc;
    int bad_rd;
    int snap;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed image: gradient, extremes, odd-sum rounding, and a row edge 50 -> 0.
    mem[100] = 16'h0A14; mem[101] = 16'h1E28;
    mem[102] = 16'h00FF; mem[103] = 16'hFFFF;
    mem[104] = 16'h0A15; mem[105] = 16'h0732;
    mem[106] = 16'h0011; mem[107] = 16'h2233;
    clear_results();
    run(1'b0, cyc, bad_rd);
    check_run("directed", cyc, bad_rd);
    check("dir_u0", 32'(wmem[0]), 32'h0A0F);
    check("dir_u1", 32'(wmem[1]), 32'h1419);
    check("dir_u2", 32'(wmem[2]), 32'h1E23);
    check("dir_u3", 32'(wmem[3]), 32'h2828);
    check("dir_extreme_ff", 32'(wmem[5]), 32'hFFFF);
    check("dir_row_edge", 32'(wmem[11]), 32'h3232);
`ifdef CHROMA_UPSAMPLE_ROUND_EN
    check("dir_round_0_255", 32'(wmem[4]), 32'h0080);
    check("dir_round_10_21", 32'(wmem[8]), 32'h0A10);
`else
    check("dir_round_0_255", 32'(wmem[4]), 32'h007F);
    check("dir_round_10_21", 32'(wmem[8]), 32'h0A0F);
`endif

    for (int n = 0; n < 3; n++) begin
      fill_random();
      clear_results();
      run(1'b0, cyc, bad_rd);
      check_run($sformatf("rand%0d", n), cyc, bad_rd);
    end

    // start coinciding with done must not launch another pass.
    fill_random();
    clear_results();
    run(1'b1, cyc, bad_rd);
    repeat (40) @(negedge clk);
    check("start_on_done_writes", 32'(wr_cnt), 32'(NWR));
    check("start_on_done_dones", 32'(done_cnt), 32'd1);
    check_image("start_on_done");

    // Abort mid-run with reset, then a clean rerun.
    fill_random();
    clear_results();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (wr_cnt < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_run", 32'(wr_cnt >= 5), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    snap = wr_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_more_writes", 32'(wr_cnt), 32'(snap));
    check("abort_no_done", 32'(done_cnt), 32'd0);
    clear_results();
    run(1'b0, cyc, bad_rd);
    check_run("rerun", cyc, bad_rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
